// File: rtl/sunflower_pkg.sv
// Shared definitions for the light optimizer: ADC word width, the sweep
// scanner state encoding and the sweep defaults used by the servo driver.
package sunflower_pkg;

    localparam int ADC_W           = 12;
    localparam int N_POS_DEF       = 16;
    localparam int POS_W_DEF       = 4;
    localparam int SETTLE_CYC_DEF  = 1000;
    localparam int ADC_TIMEOUT_DEF = 4095;

    typedef logic [ADC_W-1:0] adc_word_t;

    // Scanner FSM encoding, kept as plain constants for older tools.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_MOVE    = 3'd1;
    localparam logic [2:0] ST_SETTLE  = 3'd2;
    localparam logic [2:0] ST_REQ     = 3'd3;
    localparam logic [2:0] ST_CAPTURE = 3'd4;
    localparam logic [2:0] ST_NEXT    = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;

    // Unsigned strict compare; equality must not count as a new peak.
    function automatic logic is_greater(input adc_word_t a, input adc_word_t b);
        return (a > b);
    endfunction

endpackage

// File: rtl/light_sweep_scanner_if.sv
// ADC conversion handshake: level request from the scanner, strobed result
// from the converter.
interface light_sweep_scanner_if;
    import sunflower_pkg::*;

    logic      adc_req;
    logic      adc_valid;
    adc_word_t adc_data;

    modport master (output adc_req, input adc_valid, input adc_data);
    modport slave  (input adc_req, output adc_valid, output adc_data);

endinterface

// File: rtl/sweep_peak_tracker.sv
// Running maximum of the sweep samples and the position where it first
// appeared. Cleared at sweep start, updated once per captured sample.
module sweep_peak_tracker
    import sunflower_pkg::*;
#(
    parameter int POS_W = POS_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             update,
    input  adc_word_t        value,
    input  logic [POS_W-1:0] value_pos,
    output adc_word_t        peak_val,
    output logic [POS_W-1:0] peak_pos
);

    adc_word_t        peak_val_r;
    logic [POS_W-1:0] peak_pos_r;

    // Peak registers: strictly larger samples replace the peak, ties keep the earlier position.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            peak_val_r <= {ADC_W{1'b0}};
            peak_pos_r <= {POS_W{1'b0}};
        end else if (clear) begin
            peak_val_r <= {ADC_W{1'b0}};
            peak_pos_r <= {POS_W{1'b0}};
        end else if (update && is_greater(value, peak_val_r)) begin
            peak_val_r <= value;
            peak_pos_r <= value_pos;
        end
    end

    assign peak_val = peak_val_r;
    assign peak_pos = peak_pos_r;

endmodule

// File: rtl/light_sweep_scanner.sv
// Sweep sampler: steps the panel through N_POS positions, waits for the
// mechanics to settle, takes one ADC conversion per position and tracks the
// brightest position of the sweep.
module light_sweep_scanner
    import sunflower_pkg::*;
#(
    parameter int N_POS       = N_POS_DEF,
    parameter int POS_W       = POS_W_DEF,
    parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
    parameter int ADC_TIMEOUT = ADC_TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    light_sweep_scanner_if.master  adc,
    output logic [POS_W-1:0]       pos,
    output logic                   busy,
    output adc_word_t              sample,
    output logic                   sample_valid,
    output adc_word_t              peak_val,
    output logic [POS_W-1:0]       peak_pos,
    output logic                   done,
    output logic                   err
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int TMO_W = $clog2(ADC_TIMEOUT + 1);

    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(ADC_TIMEOUT - 1);
    localparam logic [POS_W-1:0] LAST_POS    = POS_W'(N_POS - 1);

    logic [2:0]       state_r;
    logic [2:0]       state_nxt_s;
    logic [SET_W-1:0] settle_cnt_r;
    logic [TMO_W-1:0] tmo_cnt_r;
    logic [POS_W-1:0] pos_r;
    logic             busy_r;
    logic             adc_req_r;
    adc_word_t        sample_r;
    logic             sample_valid_r;
    logic             done_r;
    logic             err_r;

    logic             start_acc_s;
    logic             handshake_s;
    logic             tmo_hit_s;
    logic             settle_zero_s;

    // Handshake only counts while the request is up (REQ state); a strobe
    // in the same cycle as the last timeout cycle still wins.
    assign start_acc_s   = (state_r == ST_IDLE) && start;
    assign handshake_s   = (state_r == ST_REQ) && adc.adc_valid;
    assign tmo_hit_s     = (state_r == ST_REQ) && !adc.adc_valid && (tmo_cnt_r == TMO_LAST);
    assign settle_zero_s = (settle_cnt_r == {SET_W{1'b0}});

    // Next-state decode for the sweep sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_MOVE;
                else       state_nxt_s = ST_IDLE;
            end
            ST_MOVE:   state_nxt_s = ST_SETTLE;
            ST_SETTLE: begin
                if (settle_zero_s) state_nxt_s = ST_REQ;
                else               state_nxt_s = ST_SETTLE;
            end
            ST_REQ: begin
                if (handshake_s)    state_nxt_s = ST_CAPTURE;
                else if (tmo_hit_s) state_nxt_s = ST_CAPTURE;
                else                state_nxt_s = ST_REQ;
            end
            ST_CAPTURE: state_nxt_s = ST_NEXT;
            ST_NEXT: begin
                if (pos_r == LAST_POS) state_nxt_s = ST_DONE;
                else                   state_nxt_s = ST_MOVE;
            end
            ST_DONE:   state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_r <= ST_IDLE;
        else          state_r <= state_nxt_s;
    end

    // Settle countdown (loaded on each move) and ADC timeout counter (cleared on each move).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            settle_cnt_r <= {SET_W{1'b0}};
            tmo_cnt_r    <= {TMO_W{1'b0}};
        end else begin
            case (state_r)
                ST_MOVE: begin
                    settle_cnt_r <= SETTLE_LOAD;
                    tmo_cnt_r    <= {TMO_W{1'b0}};
                end
                ST_SETTLE: begin
                    if (!settle_zero_s) settle_cnt_r <= settle_cnt_r - SET_W'(1);
                end
                ST_REQ: begin
                    if (!handshake_s && !tmo_hit_s) tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                end
                default: begin
                    settle_cnt_r <= settle_cnt_r;
                    tmo_cnt_r    <= tmo_cnt_r;
                end
            endcase
        end
    end

    // Sweep datapath: position, busy, captured sample and sticky timeout flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_r    <= {POS_W{1'b0}};
            busy_r   <= 1'b0;
            sample_r <= {ADC_W{1'b0}};
            err_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        pos_r  <= {POS_W{1'b0}};
                        busy_r <= 1'b1;
                        err_r  <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (handshake_s) begin
                        sample_r <= adc.adc_data;
                    end else if (tmo_hit_s) begin
                        sample_r <= {ADC_W{1'b0}};
                        err_r    <= 1'b1;
                    end
                end
                ST_NEXT: begin
                    if (pos_r != LAST_POS) pos_r <= pos_r + POS_W'(1);
                end
                ST_DONE: busy_r <= 1'b0;
                default: pos_r  <= pos_r;
            endcase
        end
    end

    // Registered strobes decoded from the state being entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            adc_req_r      <= 1'b0;
            sample_valid_r <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            adc_req_r      <= (state_nxt_s == ST_REQ);
            sample_valid_r <= (state_nxt_s == ST_CAPTURE);
            done_r         <= (state_nxt_s == ST_DONE);
        end
    end

    sweep_peak_tracker #(
        .POS_W (POS_W)
    ) u_peak (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (start_acc_s),
        .update    (state_r == ST_CAPTURE),
        .value     (sample_r),
        .value_pos (pos_r),
        .peak_val  (peak_val),
        .peak_pos  (peak_pos)
    );

    assign adc.adc_req  = adc_req_r;
    assign pos          = pos_r;
    assign busy         = busy_r;
    assign sample       = sample_r;
    assign sample_valid = sample_valid_r;
    assign done         = done_r;
    assign err          = err_r;

endmodule
